// File: rtl/divider.sv
// Sequential signed 32-bit divider (MIPS div semantics) for the HI/LO datapath.
// Restoring algorithm on magnitudes, one quotient bit per clock, signs fixed up
// in a final cycle. Remainder -> Div_HIOut, quotient -> Div_LOOut.
module divider (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Div_Start,
    input  logic [31:0] Div_A,
    input  logic [31:0] Div_B,
    output logic [31:0] Div_HIOut,
    output logic [31:0] Div_LOOut,
    output logic        Div_Busy,
    output logic        Div_Done,
    output logic        Div_Zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [31:0] r_divisor;
    logic [31:0] r_rem;        // always < divisor between steps, so 32 bits suffice
    logic [4:0]  r_count;
    logic        r_sign_rem;
    logic        r_sign_quo;
    logic        r_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_zero_pulse;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_fixed;
    logic [31:0] w_rem_fixed;

    // Magnitudes; 0x80000000 maps to itself, which is the correct unsigned value.
    assign w_abs_a = Div_A[31] ? (~Div_A + 32'd1) : Div_A;
    assign w_abs_b = Div_B[31] ? (~Div_B + 32'd1) : Div_B;

    // One restoring step: the 33-bit shifted partial remainder minus the divisor;
    // no borrow out of bit 32 means partial remainder >= divisor.
    assign w_rem_shift = {r_rem, r_dividend[31]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_diff[32];

    assign w_quo_fixed = r_sign_quo ? (~r_dividend + 32'd1) : r_dividend;
    assign w_rem_fixed = r_sign_rem ? (~r_rem + 32'd1) : r_rem;

    assign Div_HIOut = r_hi;
    assign Div_LOOut = r_lo;
    assign Div_Done  = r_done;
    assign Div_Zero  = r_zero_pulse;
    assign Div_Busy  = (r_state != S_IDLE);

    // Control FSM, datapath iteration and result registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_rem        <= '0;
            r_count      <= '0;
            r_sign_rem   <= 1'b0;
            r_sign_quo   <= 1'b0;
            r_zero       <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_done       <= 1'b0;
            r_zero_pulse <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_zero_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Div_Start) begin
                        if (Div_B == 32'd0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_FIX;
                        end else begin
                            r_dividend <= w_abs_a;
                            r_divisor  <= w_abs_b;
                            r_sign_rem <= Div_A[31];
                            r_sign_quo <= Div_A[31] ^ Div_B[31];
                            r_rem      <= '0;
                            r_count    <= '0;
                            r_zero     <= 1'b0;
                            r_state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem      <= w_ge ? w_diff[31:0] : w_rem_shift[31:0];
                    r_dividend <= {r_dividend[30:0], w_ge};
                    r_count    <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!r_zero) begin
                        r_lo <= w_quo_fixed;
                        r_hi <= w_rem_fixed;
                    end
                    r_done       <= 1'b1;
                    r_zero_pulse <= r_zero;
                    r_zero       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: expected results are queued when a division
// is started and popped when Div_Done is observed.
module tb_divider;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Div_Start;
    logic [31:0] Div_A;
    logic [31:0] Div_B;
    logic [31:0] Div_HIOut;
    logic [31:0] Div_LOOut;
    logic        Div_Busy;
    logic        Div_Done;
    logic        Div_Zero;

    divider dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Div_Start (Div_Start),
        .Div_A     (Div_A),
        .Div_B     (Div_B),
        .Div_HIOut (Div_HIOut),
        .Div_LOOut (Div_LOOut),
        .Div_Busy  (Div_Busy),
        .Div_Done  (Div_Done),
        .Div_Zero  (Div_Zero)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] held_hi  = '0;
    logic [31:0] held_lo  = '0;

    // Reference model: MIPS div via unsigned magnitudes; zero divisor keeps HI/LO.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] ua, ub, qm, rm;
        if (b == 32'd0) begin
            e.hi = held_hi; e.lo = held_lo; e.zero = 1'b1;
        end else begin
            ua = a[31] ? -a : a;
            ub = b[31] ? -b : b;
            qm = ua / ub;
            rm = ua % ub;
            e.lo = (a[31] ^ b[31]) ? -qm : qm;
            e.hi = a[31] ? -rm : rm;
            e.zero = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        sb.push_back(e);
        if (!e.zero) begin
            held_hi = e.hi;
            held_lo = e.lo;
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Drive a start for one edge, then scramble A/B (only the start edge matters).
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        Div_A = a; Div_B = b; Div_Start = 1'b1;
        tick();
        Div_Start = 1'b0;
        Div_A = $urandom;
        Div_B = $urandom;
    endtask

    // Bounded wait for Div_Done; returns cycles elapsed since the call.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (Div_Done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Div_Start = 1'b0; Div_A = '0; Div_B = '0;
        tick(); tick();
        checks++;
        if ({Div_HIOut, Div_LOOut, Div_Busy, Div_Done, Div_Zero} !== 67'd0)
            $display("FAIL reset_state hi=%h lo=%h busy=%b done=%b zero=%b required all 0",
                     Div_HIOut, Div_LOOut, Div_Busy, Div_Done, Div_Zero);
        if ({Div_HIOut, Div_LOOut, Div_Busy, Div_Done, Div_Zero} !== 67'd0) failures++;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_divide;
        logic [31:0] va[12], vb[12], ehi[6], elo[6];
        exp_t e, got;
        int   cyc;
        va[0] = 32'd7;          vb[0] = 32'd2;          elo[0] = 32'd3;          ehi[0] = 32'd1;
        va[1] = 32'hFFFFFFF9;   vb[1] = 32'd2;          elo[1] = 32'hFFFFFFFD;   ehi[1] = 32'hFFFFFFFF;
        va[2] = 32'd7;          vb[2] = 32'hFFFFFFFE;   elo[2] = 32'hFFFFFFFD;   ehi[2] = 32'd1;
        va[3] = 32'h80000000;   vb[3] = 32'hFFFFFFFF;   elo[3] = 32'h80000000;   ehi[3] = 32'd0;
        va[4] = 32'd5;          vb[4] = 32'd9;          elo[4] = 32'd0;          ehi[4] = 32'd5;
        va[5] = 32'h80000000;   vb[5] = 32'd1;          elo[5] = 32'h80000000;   ehi[5] = 32'd0;
        va[6] = 32'hFFFFFFFF;   vb[6] = 32'h7FFFFFFF;
        va[7] = 32'd0;          vb[7] = 32'h80000000;
        for (int i = 8; i < 12; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom_range(1, 32'h0000FFFF);
            if (i[0]) vb[i] = -vb[i];
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                e.hi = ehi[i]; e.lo = elo[i]; e.zero = 1'b0;
            end else begin
                e = model(va[i], vb[i]);
            end
            push_exp(e);
            start_div(va[i], vb[i]);
            checks++;
            if (Div_Busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_calc[%0d] busy=%b required 1", i, Div_Busy);
            end
            wait_done(cyc);
            checks++;
            if (cyc !== 33) begin
                failures++;
                $display("FAIL latency[%0d] cycles=%0d required 33", i, cyc);
            end
            got = sb.pop_front();
            checks++;
            if (Div_LOOut !== got.lo || Div_HIOut !== got.hi || Div_Zero !== got.zero) begin
                failures++;
                $display("FAIL result[%0d] a=%h b=%h lo=%h hi=%h zero=%b required lo=%h hi=%h zero=%b",
                         i, va[i], vb[i], Div_LOOut, Div_HIOut, Div_Zero, got.lo, got.hi, got.zero);
            end
            checks++;
            if (Div_Busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_done[%0d] busy=%b required 0", i, Div_Busy);
            end
            tick();
            checks++;
            if (Div_Done !== 1'b0 || Div_Zero !== 1'b0) begin
                failures++;
                $display("FAIL pulse_width[%0d] done=%b zero=%b required 0 0", i, Div_Done, Div_Zero);
            end
        end
    endtask

    task automatic test_zero_divisor;
        exp_t e, got;
        int   cyc;
        push_exp(model(32'd7, 32'd2));
        start_div(32'd7, 32'd2);
        wait_done(cyc);
        got = sb.pop_front();
        checks++;
        if (Div_LOOut !== got.lo || Div_HIOut !== got.hi) begin
            failures++;
            $display("FAIL zero_prior lo=%h hi=%h required lo=%h hi=%h", Div_LOOut, Div_HIOut, got.lo, got.hi);
        end
        tick();
        e = model(32'd123, 32'd0);
        push_exp(e);
        start_div(32'd123, 32'd0);
        checks++;
        if (Div_Busy !== 1'b1 || Div_Done !== 1'b0) begin
            failures++;
            $display("FAIL zero_fix_busy busy=%b done=%b required 1 0", Div_Busy, Div_Done);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 1) begin
            failures++;
            $display("FAIL zero_latency cycles=%0d required 1", cyc);
        end
        got = sb.pop_front();
        checks++;
        if (Div_Zero !== 1'b1 || Div_LOOut !== got.lo || Div_HIOut !== got.hi || Div_Busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_result zero=%b lo=%h hi=%h busy=%b required 1 lo=%h hi=%h busy=0",
                     Div_Zero, Div_LOOut, Div_HIOut, Div_Busy, got.lo, got.hi);
        end
        tick();
        checks++;
        if (Div_Done !== 1'b0 || Div_Zero !== 1'b0 || Div_Busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_after done=%b zero=%b busy=%b required 0 0 0", Div_Done, Div_Zero, Div_Busy);
        end
    endtask

    task automatic test_ignored_start;
        exp_t got;
        int   cyc;
        push_exp(model(32'd100, 32'd7));
        start_div(32'd100, 32'd7);
        repeat (9) tick();
        Div_Start = 1'b1; Div_A = 32'd1; Div_B = 32'd1;
        tick();
        Div_Start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc + 10 !== 33) begin
            failures++;
            $display("FAIL ignored_latency cycles=%0d required 33", cyc + 10);
        end
        got = sb.pop_front();
        checks++;
        if (Div_LOOut !== got.lo || Div_HIOut !== got.hi || got.lo !== 32'd14 || got.hi !== 32'd2) begin
            failures++;
            $display("FAIL ignored_result lo=%h hi=%h required lo=%h hi=%h", Div_LOOut, Div_HIOut, 32'd14, 32'd2);
        end
        repeat (3) tick();
        checks++;
        if (Div_Busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_no_restart busy=%b required 0", Div_Busy);
        end
    endtask

    task automatic test_reset_mid;
        exp_t got;
        int   cyc;
        int   seen;
        start_div(32'd100, 32'd7);
        repeat (14) tick();
        Reset = 1'b1;
        tick();
        checks++;
        if ({Div_HIOut, Div_LOOut, Div_Busy, Div_Done, Div_Zero} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid hi=%h lo=%h busy=%b done=%b zero=%b required all 0",
                     Div_HIOut, Div_LOOut, Div_Busy, Div_Done, Div_Zero);
        end
        held_hi = '0; held_lo = '0;
        // Reset wins over a simultaneous start.
        Div_Start = 1'b1; Div_A = 32'd50; Div_B = 32'd5;
        tick();
        Div_Start = 1'b0; Reset = 1'b0;
        checks++;
        if (Div_Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority busy=%b required 0", Div_Busy);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Div_Done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_no_done done_pulses=%0d required 0", seen);
        end
        push_exp(model(32'd9, 32'd3));
        start_div(32'd9, 32'd3);
        wait_done(cyc);
        got = sb.pop_front();
        checks++;
        if (cyc !== 33 || Div_LOOut !== got.lo || Div_HIOut !== got.hi) begin
            failures++;
            $display("FAIL reset_next cycles=%0d lo=%h hi=%h required 33 lo=%h hi=%h",
                     cyc, Div_LOOut, Div_HIOut, got.lo, got.hi);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        exp_t got;
        int   cyc;
        push_exp(model(32'hFFFFFF9C, 32'd7));
        start_div(32'hFFFFFF9C, 32'd7);
        wait_done(cyc);
        got = sb.pop_front();
        checks++;
        if (Div_LOOut !== got.lo || Div_HIOut !== got.hi) begin
            failures++;
            $display("FAIL b2b_first lo=%h hi=%h required lo=%h hi=%h", Div_LOOut, Div_HIOut, got.lo, got.hi);
        end
        // Start again in the very cycle Div_Done is high.
        push_exp(model(32'd20, 32'hFFFFFFFA));
        start_div(32'd20, 32'hFFFFFFFA);
        checks++;
        if (Div_Busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept busy=%b required 1", Div_Busy);
        end
        wait_done(cyc);
        got = sb.pop_front();
        checks++;
        if (cyc !== 33 || Div_LOOut !== got.lo || Div_HIOut !== got.hi) begin
            failures++;
            $display("FAIL b2b_second cycles=%0d lo=%h hi=%h required 33 lo=%h hi=%h",
                     cyc, Div_LOOut, Div_HIOut, got.lo, got.hi);
        end
        // Zero-divisor start back-to-back keeps the just-written HI/LO.
        push_exp(model(32'd1, 32'd0));
        start_div(32'd1, 32'd0);
        wait_done(cyc);
        got = sb.pop_front();
        checks++;
        if (cyc !== 1 || Div_Zero !== 1'b1 || Div_LOOut !== got.lo || Div_HIOut !== got.hi) begin
            failures++;
            $display("FAIL b2b_zero cycles=%0d zero=%b lo=%h hi=%h required 1 1 lo=%h hi=%h",
                     cyc, Div_Zero, Div_LOOut, Div_HIOut, got.lo, got.hi);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_divide();
        test_zero_divisor();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_empty left=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
